// File: rtl/router_pkg.sv
// Shared widths, address and FSM encodings for the 1-to-3 packet router.
package router_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef logic [DATA_W-1:0] byte_t;

   localparam byte_t BYTE_ZERO = 8'h00;

   localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
   localparam logic [2:0] LOAD_DATA          = 3'd2;
   localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
   localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
   localparam logic [2:0] LOAD_PARITY        = 3'd5;
   localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
   localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

   function automatic byte_t parity_acc(input byte_t acc, input byte_t b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/router_parity_calc.sv
// Running XOR parity over header and payload, captured parity byte, and
// the registered mismatch flag.
module router_parity_calc
   import router_pkg::*;
(
   input  logic  clk,
   input  logic  rstn,
   input  logic  detect_addr_i,
   input  logic  lfd_state_i,
   input  logic  ld_state_i,
   input  logic  full_state_i,
   input  logic  pkt_valid_i,
   input  logic  parity_done_i,
   input  byte_t din_i,
   input  byte_t hdr_i,
   output logic  error_o
);

   byte_t int_parity_q, int_parity_d;
   byte_t pkt_parity_q, pkt_parity_d;
   logic  error_q, error_d;

   // Next-state for parity accumulators and error flag; new packet clears first.
   always_comb begin
      int_parity_d = int_parity_q;
      pkt_parity_d = pkt_parity_q;
      error_d      = error_q;
      if (detect_addr_i) begin
         int_parity_d = BYTE_ZERO;
      end else if (lfd_state_i) begin
         int_parity_d = parity_acc(int_parity_q, hdr_i);
      end else if (ld_state_i && pkt_valid_i && !full_state_i) begin
         int_parity_d = parity_acc(int_parity_q, din_i);
      end else begin
         int_parity_d = int_parity_q;
      end
      if (ld_state_i && !pkt_valid_i) begin
         pkt_parity_d = din_i;
      end else begin
         pkt_parity_d = pkt_parity_q;
      end
      if (detect_addr_i) begin
         error_d = 1'b0;
      end else if (parity_done_i) begin
         error_d = (int_parity_q != pkt_parity_q);
      end else begin
         error_d = error_q;
      end
   end

   // Parity state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         int_parity_q <= BYTE_ZERO;
         pkt_parity_q <= BYTE_ZERO;
         error_q      <= 1'b0;
      end else begin
         int_parity_q <= int_parity_d;
         pkt_parity_q <= pkt_parity_d;
         error_q      <= error_d;
      end
   end

   assign error_o = error_q;

endmodule

// File: rtl/router_reg.sv
// router_reg: header latch, FIFO write-data path and parity status of the router.
// Parity checking is built only when ROUTER_REG_PARITY_CHECK_EN is defined.
module router_reg
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              rst_int_reg,
   input  logic              detect_addr,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] din,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              error,
   output logic [DATA_W-1:0] dout
);

   byte_t hdr_q, hdr_d;
   byte_t full_q, full_d;
   byte_t dout_q, dout_d;
   logic  parity_done_q, parity_done_d;
   logic  low_pkt_valid_q, low_pkt_valid_d;
   logic  error_s;

   // Header capture and write-bus selection; a byte arriving on a full FIFO is parked.
   always_comb begin
      hdr_d  = hdr_q;
      full_d = full_q;
      dout_d = dout_q;
      if (detect_addr && pkt_valid && (din[ADDR_W-1:0] != ADDR_INVALID)) begin
         hdr_d = din;
      end else begin
         hdr_d = hdr_q;
      end
      if (lfd_state) begin
         dout_d = hdr_q;
      end else if (ld_state && !fifo_full) begin
         dout_d = din;
      end else if (ld_state && fifo_full) begin
         full_d = din;
      end else if (laf_state) begin
         dout_d = full_q;
      end else begin
         dout_d = dout_q;
      end
   end

   // Packet-end status flags; clears take priority over sets.
   always_comb begin
      low_pkt_valid_d = low_pkt_valid_q;
      parity_done_d   = parity_done_q;
      if (rst_int_reg) begin
         low_pkt_valid_d = 1'b0;
      end else if (ld_state && !pkt_valid) begin
         low_pkt_valid_d = 1'b1;
      end else begin
         low_pkt_valid_d = low_pkt_valid_q;
      end
      if (detect_addr) begin
         parity_done_d = 1'b0;
      end else if ((ld_state && !fifo_full && !pkt_valid) ||
                   (laf_state && low_pkt_valid_q && !parity_done_q)) begin
         parity_done_d = 1'b1;
      end else begin
         parity_done_d = parity_done_q;
      end
   end

   // Datapath and status registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hdr_q           <= BYTE_ZERO;
         full_q          <= BYTE_ZERO;
         dout_q          <= BYTE_ZERO;
         parity_done_q   <= 1'b0;
         low_pkt_valid_q <= 1'b0;
      end else begin
         hdr_q           <= hdr_d;
         full_q          <= full_d;
         dout_q          <= dout_d;
         parity_done_q   <= parity_done_d;
         low_pkt_valid_q <= low_pkt_valid_d;
      end
   end

`ifdef ROUTER_REG_PARITY_CHECK_EN
   router_parity_calc u_parity_calc (
      .clk           (clk),
      .rstn          (rstn),
      .detect_addr_i (detect_addr),
      .lfd_state_i   (lfd_state),
      .ld_state_i    (ld_state),
      .full_state_i  (full_state),
      .pkt_valid_i   (pkt_valid),
      .parity_done_i (parity_done_q),
      .din_i         (din),
      .hdr_i         (hdr_q),
      .error_o       (error_s)
   );
`else
   logic unused_s;
   assign unused_s = full_state;
   assign error_s  = 1'b0;
`endif

   assign dout          = dout_q;
   assign parity_done   = parity_done_q;
   assign low_pkt_valid = low_pkt_valid_q;
   assign error         = error_s;

endmodule

// File: tb/tb_router_reg.sv
// Directed-vector bench for router_reg; error expectations follow
// ROUTER_REG_PARITY_CHECK_EN (tied low when the macro is undefined).
module tb_router_reg;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       pkt_valid = 1'b0;
   logic       fifo_full = 1'b0;
   logic       rst_int_reg = 1'b0;
   logic       detect_addr = 1'b0;
   logic       ld_state = 1'b0;
   logic       laf_state = 1'b0;
   logic       full_state = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] din = 8'h00;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       error;
   logic [7:0] dout;

   int n_vec = 0;
   int n_err = 0;

`ifdef ROUTER_REG_PARITY_CHECK_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   logic [7:0] payload [6] = '{8'h11, 8'h22, 8'h43, 8'h84, 8'h5A, 8'h0F};

   router_reg dut (
      .clk           (clk),
      .rstn          (rstn),
      .pkt_valid     (pkt_valid),
      .fifo_full     (fifo_full),
      .rst_int_reg   (rst_int_reg),
      .detect_addr   (detect_addr),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .lfd_state     (lfd_state),
      .din           (din),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .error         (error),
      .dout          (dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   // Drive one cycle of strobes/data, then sample just after the rising edge.
   task automatic step(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic ff, input logic pv, input logic ri,
                       input logic [7:0] d);
      detect_addr = da;
      lfd_state   = lfd;
      ld_state    = ld;
      laf_state   = laf;
      full_state  = fs;
      fifo_full   = ff;
      pkt_valid   = pv;
      rst_int_reg = ri;
      din         = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #2;
      chk("rst_dout", dout, 8'h00);
      chk("rst_pd", parity_done, 8'h00);
      chk("rst_low", low_pkt_valid, 8'h00);
      chk("rst_err", error, 8'h00);
      @(negedge clk);
      rstn = 1'b1;

      // good packet: header 0x18, six bytes, parity 0xB9
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h18);
      chk("good_pd_clr", parity_done, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h18);
      chk("good_hdr", dout, 8'h18);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, payload[i]);
         chk("good_pay", dout, payload[i]);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB9);
      chk("good_pd", parity_done, 8'h01);
      chk("good_low", low_pkt_valid, 8'h01);
      idle();
      chk("good_err", error, 8'h00);

      // bad parity: same packet, parity byte 0xB8
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h18);
      chk("bad_pd_clr", parity_done, 8'h00);
      chk("bad_low_clr", low_pkt_valid, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h18);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, payload[i]);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB8);
      chk("bad_pd", parity_done, 8'h01);
      chk("bad_err_early", error, 8'h00);
      idle();
      chk("bad_err", error, {7'd0, PAR_EN});

      // FIFO full: header 0x25, 0x3C, 0xA5 parked, parity 0xBC parked too
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h25);
      chk("full_err_clr", error, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h25);
      chk("full_hdr", dout, 8'h25);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
      chk("full_pay", dout, 8'h3C);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
      chk("full_hold", dout, 8'h3C);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("full_state_hold", dout, 8'h3C);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("laf_dout", dout, 8'hA5);
      chk("laf_pd_low0", parity_done, 8'h00);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hBC);
      chk("par_full_hold", dout, 8'hA5);
      chk("par_full_pd", parity_done, 8'h00);
      chk("par_full_low", low_pkt_valid, 8'h01);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("par_laf_dout", dout, 8'hBC);
      chk("par_laf_pd", parity_done, 8'h01);
      idle();
      chk("par_laf_err", error, 8'h00);

      // invalid address 0x1B leaves header 0x25
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1B);
      chk("inv_pd_clr", parity_done, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("inv_hdr", dout, 8'h25);

      // clear priorities
      chk("low_pre", low_pkt_valid, 8'h01);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44);
      chk("rst_int_prio", low_pkt_valid, 8'h00);
      chk("ld_pd_set", parity_done, 8'h01);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
      chk("detect_prio", parity_done, 8'h00);
      chk("detect_low", low_pkt_valid, 8'h01);
      chk("detect_dout", dout, 8'h77);

      // asynchronous reset mid-cycle
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_dout", dout, 8'h00);
      chk("arst_low", low_pkt_valid, 8'h00);
      chk("arst_pd", parity_done, 8'h00);
      chk("arst_err", error, 8'h00);
      @(negedge clk);
      rstn = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("arst_hdr", dout, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/router_reg.md
# router_reg

Byte-wide data and parity register stage of the 1-to-3 packet router, between the input port and the three output FIFOs. It latches the header, forwards header and payload bytes to the FIFO write bus, and parks one byte when the FIFO is full. It also accumulates running parity and compares it against the trailing parity byte. All sequencing comes from the router FSM state strobes.

## Interface
- Parameters: none. Widths come from the shared package.
- `clk` in 1: rising-edge clock. One clock domain.
- `rstn` in 1: reset, asynchronous, active-low.
- `pkt_valid` in 1: input packet byte is valid. Its falling edge marks the parity byte.
- `fifo_full` in 1: the selected output FIFO is full.
- `rst_int_reg` in 1: FSM request to clear `low_pkt_valid`.
- `detect_addr` in 1: FSM in DECODE_ADDRESS. Starts a new packet.
- `ld_state` in 1: FSM in LOAD_DATA.
- `laf_state` in 1: FSM in LOAD_AFTER_FULL.
- `full_state` in 1: FSM in FIFO_FULL_STATE.
- `lfd_state` in 1: FSM in LOAD_FIRST_DATA (header write).
- `din` in 8: input byte stream.
- `parity_done` out 1: parity byte has been received.
- `low_pkt_valid` out 1: `pkt_valid` went low during LOAD_DATA.
- `error` out 1: parity mismatch.
- `dout` out 8: byte to the FIFO write bus.

## Operation
- Internal registers:
  - `hdr_reg[7:0]`: holds the header.
  - `full_reg[7:0]`: parks the byte that arrived while the FIFO was full.
  - `int_parity[7:0]`: running parity.
  - `pkt_parity[7:0]`: received parity byte.
- Header capture: `hdr_reg <= din` when `detect_addr && pkt_valid && din[1:0] != 2'b11`.
- `dout` priority, first match wins:
  1. `lfd_state`: `dout <= hdr_reg`.
  2. `ld_state && !fifo_full`: `dout <= din`.
  3. `ld_state && fifo_full`: `full_reg <= din`; `dout` holds.
  4. `laf_state`: `dout <= full_reg`.
  - Otherwise `dout` holds.
- `low_pkt_valid`:
  - `rst_int_reg` clears it to 0; this has priority.
  - `ld_state && !pkt_valid` sets it to 1.
  - Otherwise holds.
- `parity_done`:
  - `detect_addr` clears it to 0.
  - Set to 1 when `ld_state && !fifo_full && !pkt_valid`.
  - Also set to 1 when `laf_state && low_pkt_valid && !parity_done`.
  - Otherwise holds.
- `int_parity`:
  - `detect_addr` clears it to 0.
  - `lfd_state`: `int_parity <= int_parity ^ hdr_reg`.
  - `ld_state && pkt_valid && !full_state`: `int_parity <= int_parity ^ din`.
- `pkt_parity`: `pkt_parity <= din` when `ld_state && !pkt_valid`.
- `error`:
  - When `parity_done` is 1 (registered value), `error <= (int_parity != pkt_parity)`.
  - `detect_addr` clears it to 0.
  - Otherwise holds.
- All XOR is 8-bit bitwise. No carries, no width growth.

## Timing
- Reset values: every register and output is 0 (`dout`, `parity_done`, `low_pkt_valid`, `error`, and all internal registers).
- Reset mid-packet clears everything immediately. No partial state survives.
- Latency:
  - Header appears on `dout` one cycle after the `lfd_state` edge.
  - Payload `din` appears on `dout` one cycle after sampling in `ld_state`.
  - `parity_done` rises in the cycle the parity byte is sampled.
  - `error` is valid one cycle after `parity_done` rises.
- Simultaneous events:
  - `detect_addr` with a parity set condition: the clear wins.
  - `rst_int_reg` with `ld_state && !pkt_valid`: the clear wins.
- Boundary cases:
  - An address of 2'b11 never loads `hdr_reg`.
  - `fifo_full` during the parity byte: the byte is parked in `full_reg`, and `parity_done` is set later in `laf_state`.

## Configuration
- Macro `ROUTER_REG_PARITY_CHECK_EN`.
- Defined: `int_parity`, `pkt_parity` and `error` behave as described above.
- Undefined: the parity registers are removed and `error` is tied to 0. `parity_done` still operates, because the FSM depends on it.

## Structure
- Package `router_pkg` holds:
  - `DATA_W = 8`
  - `ADDR_W = 2`
  - `ADDR_INVALID = 2'b11`
  - the FSM state encoding shared with the FSM block
- Sub-module `router_parity_calc` holds `int_parity`, `pkt_parity` and the `error` compare. It is instantiated only under `ROUTER_REG_PARITY_CHECK_EN`.

## Test plan
- Reset: pull `rstn` low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Good packet:
  - Stimulus: header 0x18 (length 6, address 0), six random payload bytes, then the correct XOR parity, with FIFO never full.
  - Response: `dout` sequence is 0x18 followed by the payload; `parity_done` = 1 on the parity cycle; `low_pkt_valid` = 1; `error` = 0 one cycle later.
- Bad parity: same packet with the parity byte XORed with 0x01 -> `error` = 1 one cycle after `parity_done`.
- FIFO full:
  - Stimulus: assert `fifo_full` while payload byte 0xA5 arrives, then go to `laf_state`.
  - Response: `dout` holds its previous value, then shows 0xA5.
- Invalid address: `detect_addr` with `din` = 0x1B -> `hdr_reg` unchanged; a subsequent `lfd_state` outputs the old header.
- Clear priority: `rst_int_reg` together with `ld_state && !pkt_valid` -> `low_pkt_valid` = 0.
